tc_timer: RTL and testbench
===========================

TC_TIMER -- requirements
Module: tc_timer

Interface
REQ-001 SHALL have parameter BASE, default 32'h0000_7F00, meaning the 16-byte-aligned base address of the register window.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have port addr, input, 32, byte address from the CPU data port.
REQ-005 SHALL have port we, input, 1, write request qualifier.
REQ-006 SHALL have port byteen, input, 4, byte enables accompanying the write.
REQ-007 SHALL have port wdata, input, 32, write data.
REQ-008 SHALL have port rdata, output, 32, combinational read data.
REQ-009 SHALL have port irq, output, 1, interrupt request to the CPU.

Function
REQ-010 SHALL decode hit = (addr[31:4] == BASE[31:4]); register select = addr[3:2]: 0 CTRL, 1 PRESET, 2 COUNT, 3 reserved.
REQ-011 SHALL accept a write only when hit && we && byteen == 4'b1111; partial-byte writes SHALL be ignored.
REQ-012 SHALL implement CTRL: bit0 EN, bits[2:1] MODE (00 one-shot, 01 auto-reload, 1x treated as 00), bit3 IM (interrupt mask, 1 = enabled); bits[31:4] read 0, writes ignored.
REQ-013 SHALL treat PRESET as 32-bit read/write and COUNT as read-only; writes to COUNT and reserved offset SHALL have no effect.
REQ-014 SHALL drive rdata = selected register when hit, reserved offset reads 0, no hit reads 0; no read side effects.
REQ-015 SHALL implement FSM states IDLE, LOAD, CNT, INT.
REQ-016 IDLE: if EN == 1 go to LOAD next edge; else remain.
REQ-017 LOAD: COUNT <= PRESET; go to CNT.
REQ-018 CNT: if EN == 0 go to IDLE with COUNT held; else if COUNT > 1 COUNT <= COUNT - 1; else COUNT <= 0 and go to INT.
REQ-019 INT: set irq_flag on entry edge; MODE 00 clears EN next edge; always go to IDLE next edge.
REQ-020 irq_flag in MODE 00 SHALL stay set until any accepted CTRL write; in MODE 01 SHALL clear on leaving INT (one-cycle pulse).
REQ-021 SHALL drive irq = irq_flag && IM, purely combinational from registers.
REQ-022 Timing: EN written at edge e0 -> LOAD at e1 -> CNT with COUNT = PRESET at e2 -> INT and irq at e(2+P) for PRESET P >= 1; PRESET 0 SHALL behave as P = 1.
REQ-023 Auto-reload period SHALL be P + 3 cycles (INT, IDLE, LOAD overhead) with EN held 1.
REQ-024 Simultaneous accepted CTRL write and FSM EN clear in INT: bus write SHALL win.
REQ-025 PRESET write during CNT SHALL not affect the running COUNT; takes effect at next LOAD.
REQ-026 CTRL write with EN = 0 during CNT SHALL freeze COUNT and return to IDLE next edge; re-enabling SHALL reload from PRESET.
REQ-027 COUNT SHALL never wrap below 0.

Reset
REQ-028 On reset: CTRL = 0, PRESET = 0, COUNT = 0, irq_flag = 0, state = IDLE; irq = 0 and rdata per decode the cycle after reset.
REQ-029 Reset asserted mid-count SHALL override all bus writes and FSM transitions that cycle.

Verification
REQ-030 PRESET = 5, CTRL = 4'b1001 (EN, one-shot, IM) -> COUNT reads 5,4,3,2,1,0; irq rises 7 cycles after CTRL write edge, stays high; CTRL reads 4'b1000 afterwards.
REQ-031 Continue REQ-030: write CTRL = 0 -> irq falls next cycle; COUNT stays 0.
REQ-032 PRESET = 3, CTRL = 4'b1011 (auto-reload) -> irq one-cycle pulses every 6 cycles, EN stays 1.
REQ-033 PRESET = 10, enable, after 4 counts write CTRL EN = 0 -> COUNT frozen at 6, no irq; re-enable -> reloads 10.
REQ-034 IM = 0 with one-shot expiry -> irq stays 0; then write CTRL = 4'b1000 -> irq still 0 (flag cleared by write).
REQ-035 Write with byteen = 4'b0011 to PRESET, write to COUNT, access with addr outside BASE window -> no register changes, out-of-window rdata = 0; reset during CNT -> all registers 0, irq 0.

Source files
------------

// File: rtl/tc_timer_if.sv
// CPU data-port view of the timer register window.
// The CPU side drives the request, the timer returns read data and irq.
interface tc_timer_if;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  byteen;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        irq;

    modport master (
        output addr,
        output we,
        output byteen,
        output wdata,
        input  rdata,
        input  irq
    );

    modport slave (
        input  addr,
        input  we,
        input  byteen,
        input  wdata,
        output rdata,
        output irq
    );
endinterface

// File: rtl/tc_timer.sv
// Memory-mapped down-counting timer with one-shot and auto-reload modes.
// Registers: CTRL (EN, MODE, IM), PRESET, read-only COUNT.
module tc_timer #(
    parameter logic [31:0] BASE = 32'h0000_7F00
) (
    input  logic       clk,
    input  logic       reset,
    tc_timer_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_CNT,
        S_INT
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic        en;
    logic [1:0]  mode;
    logic        im;
    logic [31:0] preset;
    logic [31:0] count;
    logic [31:0] count_nxt;
    logic        irq_flag;
    logic        set_flag;
    logic        leave_int;

    logic        hit;
    logic [1:0]  sel;
    logic        wr_ok;
    logic        ctrl_wr;
    logic        preset_wr;
    logic        auto_reload;
    logic        unused_addr;

    assign hit         = (bus.addr[31:4] == BASE[31:4]);
    assign sel         = bus.addr[3:2];
    assign wr_ok       = hit && bus.we && (bus.byteen == 4'b1111);
    assign ctrl_wr     = wr_ok && (sel == 2'd0);
    assign preset_wr   = wr_ok && (sel == 2'd1);
    assign auto_reload = (mode == 2'b01);
    assign unused_addr = ^bus.addr[1:0];

    always_comb begin
        state_nxt = state;
        count_nxt = count;
        set_flag  = 1'b0;
        leave_int = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (en) begin
                    state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                count_nxt = preset;
                state_nxt = S_CNT;
            end
            S_CNT: begin
                if (!en) begin
                    state_nxt = S_IDLE;
                end else if (count > 32'd1) begin
                    count_nxt = count - 32'd1;
                end else begin
                    // PRESET 0 lands here too and expires like PRESET 1
                    count_nxt = 32'd0;
                    state_nxt = S_INT;
                    set_flag  = 1'b1;
                end
            end
            S_INT: begin
                state_nxt = S_IDLE;
                leave_int = 1'b1;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            count    <= 32'd0;
            en       <= 1'b0;
            mode     <= 2'b00;
            im       <= 1'b0;
            preset   <= 32'd0;
            irq_flag <= 1'b0;
        end else begin
            state <= state_nxt;
            count <= count_nxt;
            // A bus write to CTRL overrides the one-shot EN clear
            if (ctrl_wr) begin
                en   <= bus.wdata[0];
                mode <= bus.wdata[2:1];
                im   <= bus.wdata[3];
            end else if (leave_int && !auto_reload) begin
                en <= 1'b0;
            end
            if (preset_wr) begin
                preset <= bus.wdata;
            end
            if (set_flag) begin
                irq_flag <= 1'b1;
            end else if (ctrl_wr || (leave_int && auto_reload)) begin
                irq_flag <= 1'b0;
            end
        end
    end

    always_comb begin
        bus.rdata = 32'd0;
        if (hit) begin
            case (sel)
                2'd0:    bus.rdata = {28'd0, im, mode, en};
                2'd1:    bus.rdata = preset;
                2'd2:    bus.rdata = count;
                default: bus.rdata = 32'd0;
            endcase
        end
    end

    assign bus.irq = irq_flag && im;

endmodule

// File: tb/tb_tc_timer.sv
// Directed bench for tc_timer with an expected-value queue.
// Register reads and irq are sampled 1ns+ after the rising edge.
module tb_tc_timer;

    localparam logic [31:0] BASE   = 32'h0000_7F00;
    localparam logic [31:0] A_CTRL = BASE;
    localparam logic [31:0] A_PRE  = BASE + 32'd4;
    localparam logic [31:0] A_CNT  = BASE + 32'd8;
    localparam logic [31:0] A_RSV  = BASE + 32'd12;

    logic clk = 1'b0;
    logic reset = 1'b1;

    tc_timer_if bus ();

    tc_timer #(.BASE(BASE)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];

    task automatic tick(int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(logic [31:0] a, logic [31:0] d,
                      logic [3:0] be = 4'hF);
        bus.addr   = a;
        bus.wdata  = d;
        bus.byteen = be;
        bus.we     = 1'b1;
        @(posedge clk);
        #1;
        bus.we     = 1'b0;
        bus.byteen = 4'h0;
        bus.addr   = 32'd0;
    endtask

    task automatic push(string tag, logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic pop_check(logic [31:0] obs);
        exp_t e;
        tests++;
        if (sb.size() == 0) begin
            fails++;
            $display("FAIL sb_empty observed=%h", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                fails++;
                $error("FAIL %s observed=%h expected=%h",
                       e.tag, obs, e.val);
            end
        end
    endtask

    task automatic chk_reg(string tag, logic [31:0] a, logic [31:0] e);
        push(tag, e);
        bus.addr = a;
        #1;
        pop_check(bus.rdata);
        bus.addr = 32'd0;
    endtask

    task automatic chk_irq(string tag, logic e);
        push(tag, {31'd0, e});
        pop_check({31'd0, bus.irq});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        bus.addr   = 32'd0;
        bus.we     = 1'b0;
        bus.byteen = 4'h0;
        bus.wdata  = 32'd0;
        reset      = 1'b1;
        tick(2);
        reset = 1'b0;

        // reset state
        chk_reg("rst_ctrl", A_CTRL, 32'd0);
        chk_reg("rst_pre", A_PRE, 32'd0);
        chk_reg("rst_cnt", A_CNT, 32'd0);
        chk_irq("rst_irq", 1'b0);

        // one-shot, PRESET 5, IM set
        wr(A_PRE, 32'd5);
        wr(A_CTRL, 32'h9);
        for (int k = 1; k <= 7; k++) begin
            tick();
            chk_reg($sformatf("os_cnt%0d", k), A_CNT,
                    (k == 1) ? 32'd0 : ((k <= 6) ? 32'(7 - k) : 32'd0));
            chk_irq($sformatf("os_irq%0d", k), k >= 7);
        end
        tick(3);
        chk_irq("os_irq_hold", 1'b1);
        chk_reg("os_ctrl", A_CTRL, 32'h8);
        chk_reg("os_cnt_end", A_CNT, 32'd0);

        // clearing CTRL drops irq
        wr(A_CTRL, 32'h0);
        chk_irq("clr_irq", 1'b0);
        chk_reg("clr_cnt", A_CNT, 32'd0);

        // auto-reload, PRESET 3 -> 6-cycle period
        wr(A_PRE, 32'd3);
        wr(A_CTRL, 32'hB);
        for (int k = 1; k <= 18; k++) begin
            tick();
            chk_irq($sformatf("ar_irq%0d", k),
                    (k == 5) || (k == 11) || (k == 17));
        end
        chk_reg("ar_ctrl", A_CTRL, 32'hB);
        wr(A_CTRL, 32'h0);
        tick(3);

        // freeze on EN clear, reload on re-enable
        wr(A_PRE, 32'd10);
        wr(A_CTRL, 32'h1);
        tick(5);
        chk_reg("fz_cnt7", A_CNT, 32'd7);
        wr(A_CTRL, 32'h0);
        chk_reg("fz_cnt6", A_CNT, 32'd6);
        tick(3);
        chk_reg("fz_hold", A_CNT, 32'd6);
        chk_irq("fz_irq", 1'b0);
        chk_reg("fz_ctrl", A_CTRL, 32'h0);
        wr(A_CTRL, 32'h1);
        tick(2);
        chk_reg("fz_reload", A_CNT, 32'd10);
        wr(A_PRE, 32'd20);
        chk_reg("pw_run", A_CNT, 32'd9);
        wr(A_CTRL, 32'h0);
        tick();
        chk_reg("pw_hold", A_CNT, 32'd8);
        chk_reg("pw_pre", A_PRE, 32'd20);
        wr(A_CTRL, 32'h1);
        tick(2);
        chk_reg("pw_load", A_CNT, 32'd20);
        wr(A_CTRL, 32'h0);
        tick(2);

        // bus CTRL write beats the one-shot EN clear in INT
        wr(A_PRE, 32'd1);
        wr(A_CTRL, 32'h9);
        tick(3);
        chk_irq("win_int", 1'b1);
        wr(A_CTRL, 32'h9);
        chk_reg("win_ctrl", A_CTRL, 32'h9);
        chk_irq("win_clr", 1'b0);
        tick(3);
        chk_irq("win_again", 1'b1);
        wr(A_CTRL, 32'h0);
        chk_irq("win_off", 1'b0);
        chk_reg("win_cnt", A_CNT, 32'd0);

        // masked expiry, flag cleared by CTRL write
        wr(A_PRE, 32'd2);
        wr(A_CTRL, 32'h1);
        tick(6);
        chk_irq("mask_irq", 1'b0);
        chk_reg("mask_ctrl", A_CTRL, 32'h0);
        wr(A_CTRL, 32'h8);
        chk_irq("mask_unmask", 1'b0);
        chk_reg("mask_ctrl8", A_CTRL, 32'h8);
        wr(A_CTRL, 32'h0);

        // ignored writes and decode
        wr(A_PRE, 32'h1234);
        wr(A_PRE, 32'hFFFF, 4'b0011);
        chk_reg("be_pre", A_PRE, 32'h1234);
        wr(A_CNT, 32'h55);
        chk_reg("ro_cnt", A_CNT, 32'd0);
        wr(A_RSV, 32'hDEAD);
        chk_reg("rsv_rd", A_RSV, 32'd0);
        wr(BASE + 32'h14, 32'hAAAA);
        chk_reg("oow_pre", A_PRE, 32'h1234);
        chk_reg("oow_rd", BASE + 32'h14, 32'd0);
        chk_reg("oow_hi", A_PRE | 32'h8000_0000, 32'd0);
        wr(A_CTRL, 32'hFFFF_FFF0);
        chk_reg("ctrl_hi", A_CTRL, 32'd0);
        wr(A_CTRL, 32'h8, 4'b0111);
        chk_reg("ctrl_be", A_CTRL, 32'd0);

        // reset mid-count overrides a concurrent write
        wr(A_PRE, 32'd50);
        wr(A_CTRL, 32'h9);
        tick(4);
        chk_reg("rc_cnt", A_CNT, 32'd48);
        reset      = 1'b1;
        bus.addr   = A_PRE;
        bus.wdata  = 32'd77;
        bus.byteen = 4'hF;
        bus.we     = 1'b1;
        @(posedge clk);
        #1;
        reset      = 1'b0;
        bus.we     = 1'b0;
        bus.byteen = 4'h0;
        bus.addr   = 32'd0;
        chk_reg("rc_ctrl", A_CTRL, 32'd0);
        chk_reg("rc_pre", A_PRE, 32'd0);
        chk_reg("rc_cnt0", A_CNT, 32'd0);
        chk_irq("rc_irq", 1'b0);
        tick(3);
        chk_reg("rc_idle_cnt", A_CNT, 32'd0);
        chk_irq("rc_idle_irq", 1'b0);

        // PRESET 0 expires like PRESET 1
        wr(A_PRE, 32'd0);
        wr(A_CTRL, 32'h9);
        tick(2);
        chk_irq("p0_e2", 1'b0);
        tick();
        chk_irq("p0_e3", 1'b1);
        wr(A_CTRL, 32'h0);

        if (sb.size() != 0) begin
            fails++;
            $display("FAIL sb_left observed=%0d expected=0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
